// File: rtl/noise_word_fifo.sv
// noise_word_fifo: samples the asynchronous avalanche noise pin, takes one
// raw bit per rising noise edge (the value of a free-running toggle bit),
// packs the accepted bits MSB-first into 32-bit words and buffers the words
// in a FIFO that software pops one word per read strobe.
// Build option: define NOISE_DEBIAS_EN to enable von Neumann debiasing of
// the raw bits. When it is undefined every raw bit is accepted directly.
module noise_word_fifo #(
    parameter int FIFO_ADDR_BITS = 3
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      noise_in,
    input  logic                      rd_en,
    input  logic                      clr_overflow,
    output logic [31:0]               data_out,
    output logic                      rd_ack,
    output logic [FIFO_ADDR_BITS:0]   fifo_count,
    output logic                      fifo_empty,
    output logic                      overflow
);

    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam logic [FIFO_ADDR_BITS:0]   FULL_COUNT = {1'b1, {FIFO_ADDR_BITS{1'b0}}};
    localparam logic [FIFO_ADDR_BITS:0]   CNT_ONE    = 1;
    localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE    = 1;

    // Synchroniser, toggle source and word assembler state.
    logic        n1_q, n2_q, n3_q;
    logic        t_q;
    // Only 31 bits are stored: the 32nd accepted bit goes straight into the
    // pushed word, so the top of a full 32-bit shifter would never be read.
    logic [30:0] sr_q;
    logic [4:0]  bit_cnt_q;

    // FIFO state.
    logic [31:0]               mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_BITS:0]   count_q, count_d;
    logic [31:0]               data_q;
    logic                      ack_q;
    logic                      ovf_q, ovf_d;

    logic        edge_w;
    logic        raw_bit;
    logic        acc_valid;
    logic        acc_bit;
    logic        push_w;
    logic [31:0] push_word;
    logic        full_w;
    logic        pop_w;
    logic        wr_ok;
    logic        drop_w;

    // A rising noise edge is seen once it has crossed two flops.
    assign edge_w  = n2_q & ~n3_q;
    assign raw_bit = t_q;

`ifdef NOISE_DEBIAS_EN
    logic phase_q;   // 0: next raw bit is the first of a pair
    logic first_q;   // first bit of the pair in progress

    // Pair tracking for von Neumann debiasing.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            phase_q <= 1'b0;
            first_q <= 1'b0;
        end else if (edge_w) begin
            phase_q <= ~phase_q;
            if (!phase_q) first_q <= raw_bit;
        end
    end

    // Only an unequal pair yields a bit, and that bit is the pair's first.
    assign acc_valid = edge_w & phase_q & (first_q != raw_bit);
    assign acc_bit   = first_q;
`else
    assign acc_valid = edge_w;
    assign acc_bit   = raw_bit;
`endif

    assign push_w    = acc_valid & (bit_cnt_q == 5'd31);
    assign push_word = {sr_q, acc_bit};

    assign full_w = (count_q == FULL_COUNT);
    assign pop_w  = rd_en & (count_q != '0);
    // A full FIFO still takes the word when a pop frees the head slot.
    assign wr_ok  = push_w & (~full_w | pop_w);
    assign drop_w = push_w & full_w & ~pop_w;

    // Next-state for the occupancy count and the sticky overflow flag.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        count_d = count_q;
        ovf_d   = ovf_q;
        if (wr_ok && !pop_w)      count_d = count_q + CNT_ONE;
        else if (pop_w && !wr_ok) count_d = count_q - CNT_ONE;
        if (clr_overflow) ovf_d = 1'b0;
        if (drop_w)       ovf_d = 1'b1;   // a new drop beats a clear
    end

    // Synchroniser, toggle bit and bit assembler.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, regardless of statement order.
        if (sys_rst) begin
            n1_q      <= 1'b0;
            n2_q      <= 1'b0;
            n3_q      <= 1'b0;
            t_q       <= 1'b0;
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            n1_q <= noise_in;
            n2_q <= n1_q;
            n3_q <= n2_q;
            t_q  <= ~t_q;
            if (acc_valid) begin
                sr_q      <= {sr_q[29:0], acc_bit};
                bit_cnt_q <= bit_cnt_q + 5'd1;   // wraps to 0 on the push
            end
        end
    end

    // Word storage, written synchronously.
    always_ff @(posedge sys_clk) begin
        // NOTE: storage has no reset; entries are only read after being
        // written, and leaving it unreset lets it map onto RAM.
        if (wr_ok) mem[wr_ptr_q] <= push_word;
    end

    // Pointers, count, overflow flag and the registered read port.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            ack_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ack_q   <= pop_w;
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_w) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            // A read of an empty FIFO returns zero; no read holds the word.
            if (rd_en) data_q <= pop_w ? mem[rd_ptr_q] : 32'h0;
        end
    end

    assign data_out   = data_q;
    assign rd_ack     = ack_q;
    assign fifo_count = count_q;
    assign fifo_empty = (count_q == '0);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_noise_word_fifo.sv
// Self-checking bench for noise_word_fifo: directed scenarios plus random
// noise/read/clear traffic, compared every cycle against a queue-based model.
// Define NOISE_DEBIAS_EN for both the bench and the design to test debiasing.
module tb_noise_word_fifo;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          noise_in = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_overflow = 1'b0;
    logic [31:0]   data_out;
    logic          rd_ack;
    logic [AW:0]   fifo_count;
    logic          fifo_empty;
    logic          overflow;

    noise_word_fifo #(.FIFO_ADDR_BITS(AW)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .noise_in     (noise_in),
        .rd_en        (rd_en),
        .clr_overflow (clr_overflow),
        .data_out     (data_out),
        .rd_ack       (rd_ack),
        .fifo_count   (fifo_count),
        .fifo_empty   (fifo_empty),
        .overflow     (overflow)
    );

    always #10 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit rand_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    bit          hist[$];        // noise_in seen at each edge since reset
    int          mdl_edges = 0;  // clock edges since reset
    bit          have_a = 0;
    bit          pair_a = 0;
    logic [31:0] mdl_word = '0;
    int          mdl_nbits = 0;
    logic [31:0] mdl_q[$];
    logic [31:0] exp_data = '0;
    bit          exp_ack = 0;
    bit          exp_ovf = 0;

    task automatic model_step();
        bit          raw_seen, raw, acc_seen, acc, push;
        logic [31:0] word;
        int          n;
        acc_seen = 0; acc = 0; push = 0; word = '0;
        mdl_edges++;
        hist.push_back(noise_in);
        if (hist.size() > 8) void'(hist.pop_front());
        n = hist.size();
        // A rise becomes a raw bit two edges after it is first sampled;
        // the bit is the parity of the edge count just before that edge.
        raw_seen = hist[n-3] && !hist[n-4];
        raw      = bit'((mdl_edges - 1) % 2);
        if (raw_seen) begin
`ifdef NOISE_DEBIAS_EN
            if (!have_a) begin
                have_a = 1; pair_a = raw;
            end else begin
                have_a = 0;
                if (pair_a != raw) begin acc_seen = 1; acc = pair_a; end
            end
`else
            acc_seen = 1; acc = raw;
`endif
        end
        if (acc_seen) begin
            mdl_word = {mdl_word[30:0], acc};
            mdl_nbits++;
            if (mdl_nbits == 32) begin push = 1; word = mdl_word; mdl_nbits = 0; end
        end
        if (rd_en) begin
            if (mdl_q.size() > 0) begin exp_data = mdl_q.pop_front(); exp_ack = 1; end
            else begin exp_data = '0; exp_ack = 0; end
        end else exp_ack = 0;
        if (clr_overflow) exp_ovf = 0;
        if (push) begin
            if (mdl_q.size() < DEPTH) mdl_q.push_back(word);
            else exp_ovf = 1;
        end
    endtask

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hist = '{0, 0, 0, 0};
            mdl_edges = 0; have_a = 0; pair_a = 0;
            mdl_word = '0; mdl_nbits = 0;
            mdl_q.delete();
            exp_data = '0; exp_ack = 0; exp_ovf = 0;
        end else model_step();
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge sys_clk) begin
        check("data_out",   data_out,        exp_data);
        check("rd_ack",     32'(rd_ack),     32'(exp_ack));
        check("fifo_count", 32'(fifo_count), 32'(mdl_q.size()));
        check("fifo_empty", 32'(fifo_empty), 32'(mdl_q.size() == 0));
        check("overflow",   32'(overflow),   32'(exp_ovf));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge sys_clk);
        if (rand_mode) begin
            rd_en        = ($urandom % 3) == 0;
            clr_overflow = ($urandom % 8) == 0;
        end
    endtask

    // Produce one raw bit b: time the noise rise so the toggle bit equals b.
    task automatic send_bit(input bit b);
        noise_in = 1'b0;
        tick();
        if (((mdl_edges + 1) % 2) != (b ? 0 : 1)) tick();
        noise_in = 1'b1;
        tick();
    endtask

    // Produce one bit accepted by the assembler.
    task automatic send_acc(input bit b);
`ifdef NOISE_DEBIAS_EN
        send_bit(b);
        send_bit(~b);
`else
        send_bit(b);
`endif
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_acc(w[i]);
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check(tag, data_out, exp);
        check("pop_ack", 32'(rd_ack), 32'd1);
    endtask

    // Assert reset between clock edges and check outputs before any edge.
    task automatic do_reset();
        #3 sys_rst = 1'b1;
        noise_in = 1'b0;
        #1;
        check("rst_data",  data_out,        32'h0);
        check("rst_ack",   32'(rd_ack),     32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_ovf",   32'(overflow),   32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        repeat (2) @(negedge sys_clk);
        check("init_count", 32'(fifo_count), 32'd0);
        check("init_empty", 32'(fifo_empty), 32'd1);
        sys_rst = 1'b0;

        // All-ones word, then pop it.
`ifdef NOISE_DEBIAS_EN
        for (int i = 0; i < 32; i++) begin send_bit(1'b1); send_bit(1'b0); end
`else
        for (int i = 0; i < 32; i++) send_bit(1'b1);
`endif
        settle();
        check("ones_count", 32'(fifo_count), 32'd1);
        pop_expect("ones_word", 32'hFFFF_FFFF);
        check("ones_drained", 32'(fifo_count), 32'd0);

`ifdef NOISE_DEBIAS_EN
        // Equal pairs are discarded entirely.
        for (int i = 0; i < 16; i++) begin send_bit(1'b0); send_bit(1'b0); end
        for (int i = 0; i < 16; i++) begin send_bit(1'b1); send_bit(1'b1); end
        settle();
        check("equal_pairs_count", 32'(fifo_count), 32'd0);
`endif

        // Asynchronous reset with a stored word and a non-zero data_out.
        send_word($urandom);
        settle();
        do_reset();

        // Overflow: nine words into an eight-deep FIFO.
        for (int k = 0; k < 9; k++) send_word(32'(k));
        settle();
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_flag",  32'(overflow),   32'd1);
        for (int k = 0; k < 8; k++) pop_expect("ovf_order", 32'(k));
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Read of an empty FIFO.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("empty_data", data_out, 32'h0);
        check("empty_ack",  32'(rd_ack), 32'd0);

        // Full FIFO: pop in the same cycle as a push.
        for (int k = 0; k < 8; k++) send_word($urandom);
        settle();
        w = $urandom;
        send_word(w);
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fullpop_count", 32'(fifo_count), 32'd8);
        check("fullpop_ovf",   32'(overflow),   32'd0);
        rd_en = 1'b1;
        repeat (10) tick();
        rd_en = 1'b0;
        tick();
        check("drain_count", 32'(fifo_count), 32'd0);

        // Reset in the middle of a word discards the partial word.
        for (int i = 0; i < 20; i++) send_acc(1'b1);
        do_reset();
        for (int i = 0; i < 32; i++) send_acc(1'b0);
        settle();
        check("midword_count", 32'(fifo_count), 32'd1);
        pop_expect("midword_word", 32'h0);

        // Random noise with random reads and clears.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) send_bit(1'($urandom % 2));
        rand_mode = 1'b0;
        rd_en = 1'b0;
        clr_overflow = 1'b0;
        settle();
        rd_en = 1'b1;
        repeat (DEPTH + 2) tick();
        rd_en = 1'b0;
        tick();
        check("final_count", 32'(fifo_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
